// File: rtl/pc_gen_pkg.sv
// -----------------------------------------------------------------------------
// pc_gen_pkg
// Shared constants for the fetch-address generator and its BTB:
//   DEF_AW, DEF_RESET_VEC, DEF_BTB_DEPTH : default widths / reset vector / size
//   INSTR_STEP                           : sequential fetch increment (bytes)
//   BRANCH_TAKEN, NO_STOP                : control-level encodings
// Also provides 2-bit saturating counter helpers. These are used only when
// PCGEN_BHT_EN is defined.
// -----------------------------------------------------------------------------
package pc_gen_pkg;

  localparam int          DEF_AW        = 32;
  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam int          DEF_BTB_DEPTH = 16;
  localparam int          INSTR_STEP    = 4;

  // Level encodings of the control inputs
  localparam logic BRANCH_TAKEN = 1'b1;
  localparam logic NO_STOP      = 1'b0;

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

endpackage

// File: rtl/pc_btb.sv
// -----------------------------------------------------------------------------
// pc_btb
// Direct-mapped branch target buffer. Lookup is combinational from registered
// storage, so an update to an index is only visible from the following cycle.
// Optional feature macro: PCGEN_BHT_EN. When it is defined, each entry gets a
// 2-bit saturating counter and a prediction needs counter >= 2.
// Ports:
//   clk, rst      : clock, async active-high reset (clears valid bits/counters)
//   i_lk_en       : lookup enable (fetch PC valid)
//   i_lk_pc       : lookup address
//   o_hit         : predict taken
//   o_target      : predicted target (0 when no hit)
//   i_up_valid    : update strobe
//   i_up_pc       : PC of the resolved instruction
//   i_up_taken    : resolved direction
//   i_up_target   : resolved target (bits [1:0] are not stored)
// -----------------------------------------------------------------------------
module pc_btb
  import pc_gen_pkg::*;
#(
  parameter int AW        = DEF_AW,
  parameter int BTB_DEPTH = DEF_BTB_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_lk_en,
  input  logic [AW-1:0] i_lk_pc,
  output logic          o_hit,
  output logic [AW-1:0] o_target,
  input  logic          i_up_valid,
  input  logic [AW-1:0] i_up_pc,
  input  logic          i_up_taken,
  input  logic [AW-1:0] i_up_target
);

  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = AW - IDX_W - 2;

  logic [BTB_DEPTH-1:0] r_valid;
  logic [TAG_W-1:0]     r_tag [BTB_DEPTH];
  logic [AW-3:0]        r_tgt [BTB_DEPTH];

  logic [IDX_W-1:0] w_lk_idx;
  logic [TAG_W-1:0] w_lk_tag;
  logic [IDX_W-1:0] w_up_idx;
  logic [TAG_W-1:0] w_up_tag;
  logic             w_up_match;
  logic             w_lk_hit;
  logic             w_unused_bits;

  assign w_lk_idx   = i_lk_pc[IDX_W+1:2];
  assign w_lk_tag   = i_lk_pc[AW-1:IDX_W+2];
  assign w_up_idx   = i_up_pc[IDX_W+1:2];
  assign w_up_tag   = i_up_pc[AW-1:IDX_W+2];
  assign w_up_match = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

  // Byte-offset bits carry no information for word-aligned fetch
  assign w_unused_bits = ^{i_lk_pc[1:0], i_up_pc[1:0], i_up_target[1:0]};

`ifdef PCGEN_BHT_EN
  localparam logic [1:0] CTR_ALLOC = 2'b10;  // weakly taken on allocation
  logic [1:0] r_ctr [BTB_DEPTH];

  assign w_lk_hit = i_lk_en && r_valid[w_lk_idx] &&
                    (r_tag[w_lk_idx] == w_lk_tag) && r_ctr[w_lk_idx][1];
`else
  assign w_lk_hit = i_lk_en && r_valid[w_lk_idx] &&
                    (r_tag[w_lk_idx] == w_lk_tag);
`endif

  assign o_hit    = w_lk_hit;
  assign o_target = w_lk_hit ? {r_tgt[w_lk_idx], 2'b00} : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i < BTB_DEPTH; i++) begin
        r_tag[i] <= '0;
        r_tgt[i] <= '0;
`ifdef PCGEN_BHT_EN
        r_ctr[i] <= '0;
`endif
      end
    end else if (i_up_valid) begin
      if (i_up_taken == BRANCH_TAKEN) begin
        r_valid[w_up_idx] <= 1'b1;
        r_tag[w_up_idx]   <= w_up_tag;
        r_tgt[w_up_idx]   <= i_up_target[AW-1:2];
`ifdef PCGEN_BHT_EN
        // A hit strengthens the entry; a miss replaces it.
        r_ctr[w_up_idx]   <= w_up_match ? ctr_inc(r_ctr[w_up_idx]) : CTR_ALLOC;
`endif
      end else if (w_up_match) begin
`ifdef PCGEN_BHT_EN
        r_ctr[w_up_idx]   <= ctr_dec(r_ctr[w_up_idx]);
`else
        r_valid[w_up_idx] <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: rtl/pc_gen.sv
// -----------------------------------------------------------------------------
// pc_gen
// Fetch-address generator: PC register, next-PC priority mux, flush pulse and
// a direct-mapped BTB (pc_btb). Optional feature macro: PCGEN_BHT_EN (2-bit
// counters in the BTB).
// Handshake: pc_valid/pc_ready is a plain valid/ready pair. The current pc is
// consumed on a clock edge where pc_valid & pc_ready & ~stall. pc is held
// otherwise. An EX redirect replaces pc regardless of the handshake.
// Ports:
//   clk, rst            : clock, async active-high reset
//   stall, pc_ready     : freeze / IF accept
//   ex_redirect/target  : redirect from EX (highest priority)
//   ex_br_*             : BTB update from a resolved control-flow instruction
//   pc, pc_valid        : fetch request to IF
//   pred_taken/target   : combinational BTB prediction for pc
//   flush_o             : registered, one cycle after a redirect is taken
// -----------------------------------------------------------------------------
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int            AW        = DEF_AW,
  parameter logic [AW-1:0] RESET_VEC = AW'(DEF_RESET_VEC),
  parameter int            BTB_DEPTH = DEF_BTB_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          pc_ready,
  input  logic          ex_redirect,
  input  logic [AW-1:0] ex_target,
  input  logic          ex_br_valid,
  input  logic [AW-1:0] ex_br_pc,
  input  logic          ex_br_taken,
  input  logic [AW-1:0] ex_br_target,
  output logic [AW-1:0] pc,
  output logic          pc_valid,
  output logic          pred_taken,
  output logic [AW-1:0] pred_target,
  output logic          flush_o
);

  logic [AW-1:0] r_pc;
  logic          r_pc_valid;
  logic          r_flush;

  logic          w_acc;
  logic          w_hit;
  logic [AW-1:0] w_hit_target;
  logic [AW-1:0] w_next_seq;

  pc_btb #(
    .AW        (AW),
    .BTB_DEPTH (BTB_DEPTH)
  ) u_btb (
    .clk         (clk),
    .rst         (rst),
    .i_lk_en     (r_pc_valid),
    .i_lk_pc     (r_pc),
    .o_hit       (w_hit),
    .o_target    (w_hit_target),
    .i_up_valid  (ex_br_valid),
    .i_up_pc     (ex_br_pc),
    .i_up_taken  (ex_br_taken),
    .i_up_target (ex_br_target)
  );

  assign w_acc      = r_pc_valid && pc_ready && (stall == NO_STOP);
  // Adder wraps naturally at 2^AW
  assign w_next_seq = w_hit ? w_hit_target : r_pc + AW'(INSTR_STEP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= RESET_VEC;
      r_pc_valid <= 1'b0;
      r_flush    <= 1'b0;
    end else begin
      // First edge out of reset only raises pc_valid: w_acc is 0 here.
      r_pc_valid <= 1'b1;
      if (ex_redirect) begin
        r_pc    <= ex_target;
        r_flush <= 1'b1;
      end else begin
        r_flush <= 1'b0;
        if (w_acc) begin
          r_pc <= w_next_seq;
        end
      end
    end
  end

  assign pc          = r_pc;
  assign pc_valid    = r_pc_valid;
  assign pred_taken  = w_hit;
  assign pred_target = w_hit_target;
  assign flush_o     = r_flush;

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

  localparam int AW    = 32;
  localparam int DEPTH = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          stall, pc_ready, ex_redirect, ex_br_valid, ex_br_taken;
  logic [AW-1:0] ex_target, ex_br_pc, ex_br_target;
  logic [AW-1:0] pc, pred_target;
  logic          pc_valid, pred_taken, flush_o;

  pc_gen dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .pc_ready     (pc_ready),
    .ex_redirect  (ex_redirect),
    .ex_target    (ex_target),
    .ex_br_valid  (ex_br_valid),
    .ex_br_pc     (ex_br_pc),
    .ex_br_taken  (ex_br_taken),
    .ex_br_target (ex_br_target),
    .pc           (pc),
    .pc_valid     (pc_valid),
    .pred_taken   (pred_taken),
    .pred_target  (pred_target),
    .flush_o      (flush_o)
  );

  // ---------------- reference model ----------------
  int n_assert = 0;
  int n_fail   = 0;

  logic [AW-1:0] m_pc;
  bit            m_valid, m_flush;
  bit            m_v   [DEPTH];
  logic [AW-1:0] m_tag [DEPTH];
  logic [AW-1:0] m_tgt [DEPTH];
  int            m_ctr [DEPTH];
  logic [AW-1:0] exp_q [$];

  task automatic m_reset();
    m_pc    = '0;
    m_valid = 0;
    m_flush = 0;
    for (int i = 0; i < DEPTH; i++) begin
      m_v[i] = 0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 0;
    end
  endtask

  function automatic int slot(input logic [AW-1:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  function automatic logic [AW-1:0] tag_of(input logic [AW-1:0] a);
    return a / (4 * DEPTH);
  endfunction

  function automatic bit m_hit();
    int s;
    bit h;
    s = slot(m_pc);
    h = m_valid && m_v[s] && (m_tag[s] == tag_of(m_pc));
`ifdef PCGEN_BHT_EN
    h = h && (m_ctr[s] >= 2);
`endif
    return h;
  endfunction

  task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // One clock: check combinational prediction at negedge, predict next state,
  // then check registered outputs just after the posedge.
  task automatic cycle(input string tag);
    bit            hit, acc, nxt_flush, match;
    logic [AW-1:0] tgt, nxt_pc;
    int            s;
    @(negedge clk);
    hit = m_hit();
    tgt = hit ? m_tgt[slot(m_pc)] : '0;
    chk({tag, "/pred_taken"}, AW'(pred_taken), AW'(hit));
    chk({tag, "/pred_target"}, pred_target, tgt);
    acc       = m_valid && pc_ready && !stall;
    nxt_pc    = m_pc;
    nxt_flush = 0;
    if (ex_redirect) begin
      nxt_pc    = ex_target;
      nxt_flush = 1;
    end else if (acc) begin
      nxt_pc = hit ? tgt : m_pc + 32'd4;
    end
    exp_q.push_back(nxt_pc);
    @(posedge clk);
    #1;
    if (ex_br_valid) begin
      s     = slot(ex_br_pc);
      match = m_v[s] && (m_tag[s] == tag_of(ex_br_pc));
      if (ex_br_taken) begin
`ifdef PCGEN_BHT_EN
        m_ctr[s] = match ? ((m_ctr[s] < 3) ? m_ctr[s] + 1 : 3) : 2;
`endif
        m_v[s]   = 1;
        m_tag[s] = tag_of(ex_br_pc);
        m_tgt[s] = ex_br_target & ~32'd3;
      end else if (match) begin
`ifdef PCGEN_BHT_EN
        m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
`else
        m_v[s] = 0;
`endif
      end
    end
    m_pc    = nxt_pc;
    m_valid = 1;
    m_flush = nxt_flush;
    chk({tag, "/pc"}, pc, exp_q.pop_front());
    chk({tag, "/pc_valid"}, AW'(pc_valid), 32'd1);
    chk({tag, "/flush_o"}, AW'(flush_o), AW'(m_flush));
  endtask

  task automatic redirect_to(input logic [AW-1:0] a);
    ex_redirect = 1; ex_target = a;
    cycle("redirect");
    ex_redirect = 0;
  endtask

  task automatic br_update(input logic [AW-1:0] bpc, input logic tk, input logic [AW-1:0] btgt);
    ex_br_valid = 1; ex_br_pc = bpc; ex_br_taken = tk; ex_br_target = btgt;
    cycle("br_update");
    ex_br_valid = 0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "/pc"}, pc, 32'h0);
    chk({tag, "/pc_valid"}, AW'(pc_valid), 32'd0);
    chk({tag, "/flush_o"}, AW'(flush_o), 32'd0);
    chk({tag, "/pred_taken"}, AW'(pred_taken), 32'd0);
    chk({tag, "/pred_target"}, pred_target, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    rst = 1; stall = 0; pc_ready = 0; ex_redirect = 0; ex_target = '0;
    ex_br_valid = 0; ex_br_pc = '0; ex_br_taken = 0; ex_br_target = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset");

    // Release: pc_valid on first edge, then 0 -> 4 -> 8 -> 0xC -> 0x10
    rst = 0; pc_ready = 1;
    cycle("release");
    chk("release_pc0", pc, 32'h0);
    repeat (4) cycle("seq");
    chk("seq_pc10", pc, 32'h10);

    // Stall and not-ready hold the PC
    stall = 1;
    repeat (3) cycle("stall");
    stall = 0; pc_ready = 0;
    cycle("not_ready");
    chk("held_pc10", pc, 32'h10);
    pc_ready = 1;
    cycle("resume");
    chk("resume_pc14", pc, 32'h14);

    // Redirect overrides stall, flush_o for exactly one cycle
    stall = 1;
    redirect_to(32'h200);
    chk("redir_pc", pc, 32'h200);
    chk("redir_flush", AW'(flush_o), 32'd1);
    stall = 0;
    cycle("post_redir");
    chk("post_redir_flush", AW'(flush_o), 32'd0);

    // BTB hit on sequential fetch
    br_update(32'h40, 1, 32'h100);
    redirect_to(32'h38);
    repeat (2) cycle("to_40");
    chk("at_40", pc, 32'h40);
    cycle("btb_hit");
    chk("btb_hit_pc", pc, 32'h100);

    // Not-taken update removes the prediction
    br_update(32'h40, 0, 32'h0);
    redirect_to(32'h40);
    cycle("after_nt");
    chk("after_nt_pc", pc, 32'h44);

    // Alias: same index, different tag never hits
    br_update(32'h40, 1, 32'h100);
    redirect_to(32'h80);
    cycle("alias");
    chk("alias_pc", pc, 32'h84);

    // Wrap at top of address space
    redirect_to(32'hFFFF_FFFC);
    cycle("wrap");
    chk("wrap_pc", pc, 32'h0);

    // Same-cycle lookup/update collision: old prediction this cycle
    redirect_to(32'h40);
    stall = 1;
    ex_br_valid = 1; ex_br_pc = 32'h40; ex_br_taken = 1; ex_br_target = 32'h300;
    cycle("collide");
    ex_br_valid = 0;
    chk("collide_new_tgt", pred_target, 32'h300);
    cycle("collide_hold");
    stall = 0;
    cycle("collide_take");
    chk("collide_pc", pc, 32'h300);

    // Mid-cycle reset drops a pending update
    ex_br_valid = 1; ex_br_pc = 32'h8; ex_br_taken = 1; ex_br_target = 32'h500;
    #2 rst = 1;
    #1;
    chk_reset_state("mid_reset");
    m_reset();
    @(posedge clk);
    #1;
    rst = 0; ex_br_valid = 0;
    repeat (4) cycle("post_reset");
    chk("post_reset_pc", pc, 32'hC);

    // Random traffic against the model
    repeat (400) begin
      stall        = ($urandom_range(0, 3) == 0);
      pc_ready     = ($urandom_range(0, 4) != 0);
      ex_redirect  = ($urandom_range(0, 9) == 0);
      ex_target    = 32'($urandom_range(0, 63)) * 4;
      ex_br_valid  = ($urandom_range(0, 2) == 0);
      ex_br_pc     = 32'($urandom_range(0, 63)) * 4;
      ex_br_taken  = ($urandom_range(0, 2) != 0);
      ex_br_target = 32'($urandom_range(0, 255));
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
